board_io_ctrl: RTL

Parametrised board I/O front-end sitting between raw push-buttons/LEDs and the SpinalHDL core inside the board toplevel. Runs on the PLL-derived main clock. Per channel it synchronises and debounces one button, emits press pulses, and runs a mode FSM (OFF/ON/BLINK) that drives one LED. It generalises the fixed two-button/one-LED wiring to NUM_CH channels with real debounce and blink behaviour.

---
 rtl/board_io_pkg.sv | 15 +
 rtl/board_io_debounce.sv | 92 +++++++++
 rtl/board_io_ctrl.sv | 91 +++++++++
 3 files changed

// File: rtl/board_io_pkg.sv
// Shared definitions for the board I/O front-end: LED mode encoding and counter sizing.
package board_io_pkg;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_ON    = 2'd1,
    MODE_BLINK = 2'd2
  } mode_t;

  // Bits needed to hold 0..n-1, never less than one.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/board_io_debounce.sv
// One button: polarity fix, 2-FF sync, debounce (DEB_CYCLES+2 edges), registered press pulse; no backpressure.
// BOARD_IO_LONGPRESS_EN adds a saturating hold counter that pulses long_pulse once per hold.
module board_io_debounce
  import board_io_pkg::*;
#(
  parameter int BTN_ACTIVE_LOW = 1,
  parameter int DEB_CYCLES     = 120000,
  parameter int LONG_CYCLES    = 24000000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic level,
  output logic press,
  output logic long_pulse
);

  localparam int             DW      = cnt_w(DEB_CYCLES);
  localparam logic [DW-1:0]  DEB_MAX = DW'(DEB_CYCLES - 1);

  logic          btn_in;
  logic          sync1_q, sync1_d, sync2_q, sync2_d;
  logic          stable_q, stable_d, press_q, press_d;
  logic [DW-1:0] cnt_q, cnt_d;

  assign btn_in = (BTN_ACTIVE_LOW != 0) ? ~btn_raw : btn_raw;

  always_comb begin
    sync1_d  = btn_in;
    sync2_d  = sync1_q;
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync2_q != stable_q) begin
      if (cnt_q == DEB_MAX) stable_d = sync2_q;
      else                  cnt_d    = cnt_q + 1'b1;
    end
    press_d = stable_d & ~stable_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      press_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
      press_q  <= press_d;
      cnt_q    <= cnt_d;
    end
  end

  assign level = stable_q;
  assign press = press_q;

`ifdef BOARD_IO_LONGPRESS_EN
  localparam int            LW       = cnt_w(LONG_CYCLES);
  localparam logic [LW-1:0] LONG_MAX = LW'(LONG_CYCLES - 1);

  logic [LW-1:0] hold_q, hold_d;
  logic          long_q, long_d;

  // Saturates at LONG_MAX so the pulse fires only on the step into it.
  always_comb begin
    hold_d = '0;
    long_d = 1'b0;
    if (stable_q) begin
      hold_d = (hold_q == LONG_MAX) ? hold_q : hold_q + 1'b1;
      long_d = (hold_d == LONG_MAX) && (hold_q != LONG_MAX);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_q <= '0;
      long_q <= 1'b0;
    end else begin
      hold_q <= hold_d;
      long_q <= long_d;
    end
  end

  assign long_pulse = long_q;
`else
  // Always 0; the comparison only keeps LONG_CYCLES referenced in this build.
  assign long_pulse = (LONG_CYCLES < 0);
`endif

endmodule

// File: rtl/board_io_ctrl.sv
// Board button/LED front-end: per-channel debounce, OFF/ON/BLINK mode FSM, LED one cycle behind io_mode; no backpressure.
// BOARD_IO_LONGPRESS_EN enables long-press detection, which forces the channel mode to OFF.
module board_io_ctrl
  import board_io_pkg::*;
#(
  parameter int NUM_CH         = 2,
  parameter int BTN_ACTIVE_LOW = 1,
  parameter int DEB_CYCLES     = 120000,
  parameter int BLINK_CYCLES   = 3000000,
  parameter int LONG_CYCLES    = 24000000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_CH-1:0]   io_btn,
  output logic [NUM_CH-1:0]   io_led,
  output logic [NUM_CH-1:0]   io_btn_level,
  output logic [NUM_CH-1:0]   io_press,
  output logic [NUM_CH-1:0]   io_long,
  output logic [2*NUM_CH-1:0] io_mode
);

  localparam int            BW        = cnt_w(BLINK_CYCLES);
  localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_CYCLES - 1);

  logic [BW-1:0]     blink_cnt_q, blink_cnt_d;
  logic              phase_q, phase_d;
  mode_t             mode_q [NUM_CH];
  mode_t             mode_d [NUM_CH];
  logic [NUM_CH-1:0] led_q, led_d;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    board_io_debounce #(
      .BTN_ACTIVE_LOW (BTN_ACTIVE_LOW),
      .DEB_CYCLES     (DEB_CYCLES),
      .LONG_CYCLES    (LONG_CYCLES)
    ) u_deb (
      .clk        (clk),
      .reset      (reset),
      .btn_raw    (io_btn[g]),
      .level      (io_btn_level[g]),
      .press      (io_press[g]),
      .long_pulse (io_long[g])
    );
    assign io_mode[2*g +: 2] = mode_q[g];
  end

  always_comb begin
    blink_cnt_d = blink_cnt_q + 1'b1;
    phase_d     = phase_q;
    led_d       = '0;
    if (blink_cnt_q == BLINK_MAX) begin
      blink_cnt_d = '0;
      phase_d     = ~phase_q;
    end
    for (int i = 0; i < NUM_CH; i++) begin
      mode_d[i] = mode_q[i];
      // A long-press force overrides a coincident press.
      if (io_long[i]) begin
        mode_d[i] = MODE_OFF;
      end else if (io_press[i]) begin
        case (mode_q[i])
          MODE_ON:    mode_d[i] = MODE_BLINK;
          MODE_BLINK: mode_d[i] = MODE_OFF;
          default:    mode_d[i] = MODE_ON;
        endcase
      end
      case (mode_q[i])
        MODE_ON:    led_d[i] = 1'b1;
        MODE_BLINK: led_d[i] = phase_q;
        default:    led_d[i] = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
      led_q       <= '0;
      for (int i = 0; i < NUM_CH; i++) mode_q[i] <= MODE_OFF;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
      led_q       <= led_d;
      for (int i = 0; i < NUM_CH; i++) mode_q[i] <= mode_d[i];
    end
  end

  assign io_led = led_q;

endmodule
